// File: rtl/midi_voice_allocator.sv
// rtl/midi_voice_allocator.sv - polyphonic MIDI voice allocator with oldest-voice stealing
module midi_voice_allocator #(
    parameter int          NUM_VOICES = 8,
    parameter logic [15:0] CH_MASK    = 16'hFFFF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_evt_valid,
    input  logic [23:0]             i_evt_data,
    output logic                    o_evt_ready,
    output logic [16*NUM_VOICES-1:0] o_voice_bus,
    output logic [NUM_VOICES-1:0]   o_voice_active,
    output logic                    o_steal_pulse
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_COMMIT} state_t;
    typedef enum logic [1:0] {K_IGNORE, K_ON, K_OFF, K_ALL} kind_t;

    localparam logic [2:0] OLDEST = 3'(NUM_VOICES - 1);

    state_t                        r_state;
    kind_t                         r_kind;
    logic [23:0]                   r_evt;
    logic [NUM_VOICES-1:0]         r_clear;
    logic [2:0]                    r_sel;
    logic                          r_steal;
    logic [NUM_VOICES-1:0][15:0]   r_voice;
    logic [NUM_VOICES-1:0][3:0]    r_chan;
    logic [NUM_VOICES-1:0][2:0]    r_rank;
    logic [NUM_VOICES-1:0]         r_active;
    logic                          r_steal_pulse;

    logic [15:0]           w_ch_mask;
    logic [3:0]            w_chan;
    logic [7:0]            w_d1;
    logic [7:0]            w_d2;
    kind_t                 w_kind;
    logic [NUM_VOICES-1:0] w_note_match;
    logic [NUM_VOICES-1:0] w_chan_match;
    logic [2:0]            w_sel_match;
    logic [2:0]            w_sel_free;
    logic [2:0]            w_sel_old;
    logic                  w_any_match;
    logic                  w_any_free;
    logic [2:0]            w_sel;

    assign w_ch_mask = CH_MASK;
    assign w_chan    = r_evt[19:16];
    assign w_d1      = r_evt[15:8];
    assign w_d2      = r_evt[7:0];

    always_comb begin
        w_kind = K_IGNORE;
        if (w_ch_mask[w_chan]) begin
            case (r_evt[23:20])
                4'h9:    w_kind = (w_d2 != 8'h00) ? K_ON : K_OFF;
                4'h8:    w_kind = K_OFF;
                4'hB:    w_kind = (w_d1 == 8'h7B || w_d1 == 8'h78) ? K_ALL : K_IGNORE;
                default: w_kind = K_IGNORE;
            endcase
        end
    end

    // Descending scan so the lowest-index candidate of each class wins.
    always_comb begin
        w_note_match = '0;
        w_chan_match = '0;
        w_sel_match  = 3'd0;
        w_sel_free   = 3'd0;
        w_sel_old    = 3'd0;
        w_any_match  = 1'b0;
        w_any_free   = 1'b0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            w_chan_match[v] = r_active[v] && (r_chan[v] == w_chan);
            w_note_match[v] = w_chan_match[v] && (r_voice[v][15:8] == w_d1);
            if (w_note_match[v]) begin
                w_sel_match = 3'(v);
                w_any_match = 1'b1;
            end
            if (!r_active[v]) begin
                w_sel_free = 3'(v);
                w_any_free = 1'b1;
            end
            if (r_rank[v] == OLDEST) begin
                w_sel_old = 3'(v);
            end
        end
        if (w_any_match) begin
            w_sel = w_sel_match;
        end else if (w_any_free) begin
            w_sel = w_sel_free;
        end else begin
            w_sel = w_sel_old;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_kind        <= K_IGNORE;
            r_evt         <= '0;
            r_clear       <= '0;
            r_sel         <= 3'd0;
            r_steal       <= 1'b0;
            r_voice       <= '0;
            r_chan        <= '0;
            r_active      <= '0;
            r_steal_pulse <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_rank[v] <= 3'(v);
            end
        end else begin
            r_steal_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_evt_valid) begin
                        r_evt   <= i_evt_data;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_kind  <= w_kind;
                    r_clear <= (w_kind == K_ALL) ? w_chan_match : w_note_match;
                    r_sel   <= w_sel;
                    r_steal <= !w_any_match && !w_any_free;
                    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (r_kind == K_ON) begin
                        r_steal_pulse <= r_steal;
                        // Rank update keeps the ages a permutation: only voices younger than the target shift.
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (3'(v) == r_sel) begin
                                r_voice[v]  <= {w_d1, w_d2};
                                r_chan[v]   <= w_chan;
                                r_active[v] <= 1'b1;
                                r_rank[v]   <= 3'd0;
                            end else if (r_rank[v] < r_rank[r_sel]) begin
                                r_rank[v] <= r_rank[v] + 3'd1;
                            end
                        end
                    end else if (r_kind == K_OFF || r_kind == K_ALL) begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (r_clear[v]) begin
                                r_voice[v]  <= 16'h0000;
                                r_active[v] <= 1'b0;
                            end
                        end
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_evt_ready    = (r_state == S_IDLE);
    assign o_voice_bus    = r_voice;
    assign o_voice_active = r_active;
    assign o_steal_pulse  = r_steal_pulse;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb/tb_midi_voice_allocator.sv - directed self-checking bench for midi_voice_allocator
module tb_midi_voice_allocator;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         evt_valid = 1'b0;
    logic [23:0]  evt_data = '0;
    logic         evt_ready;
    logic [127:0] voice_bus;
    logic [7:0]   voice_active;
    logic         steal_pulse;
    logic         m_ready;
    logic [127:0] m_bus;
    logic [7:0]   m_active;
    logic         m_steal;

    int checks = 0;
    int failures = 0;
    int steal_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (steal_pulse) steal_cnt++;

    midi_voice_allocator #(.NUM_VOICES(8), .CH_MASK(16'hFFFF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_evt_valid(evt_valid), .i_evt_data(evt_data),
        .o_evt_ready(evt_ready), .o_voice_bus(voice_bus), .o_voice_active(voice_active),
        .o_steal_pulse(steal_pulse)
    );

    midi_voice_allocator #(.NUM_VOICES(8), .CH_MASK(16'h0001)) dut_m (
        .i_clk(clk), .i_rst_n(rst_n), .i_evt_valid(evt_valid), .i_evt_data(evt_data),
        .o_evt_ready(m_ready), .o_voice_bus(m_bus), .o_voice_active(m_active),
        .o_steal_pulse(m_steal)
    );

    function automatic logic [15:0] vb(input int v);
        return voice_bus[16*v +: 16];
    endfunction

    task automatic do_reset();
        evt_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns #1 after the edge leaving COMMIT, where results are visible.
    task automatic send(input logic [23:0] d);
        int n = 0;
        @(negedge clk);
        while (!evt_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (evt_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready_timeout: evt_ready=%b required 1", evt_ready);
        end
        evt_valid = 1'b1;
        evt_data  = d;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (voice_bus !== '0 || voice_active !== 8'h00 || steal_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: bus=%h active=%h steal=%b required 0", voice_bus, voice_active, steal_pulse);
        end
        checks++;
        if (evt_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b required 1", evt_ready);
        end
        do_reset();
    endtask

    task automatic test_first_note();
        do_reset();
        @(negedge clk);
        evt_valid = 1'b1;
        evt_data  = 24'h903C64;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        checks++;
        if (evt_ready !== 1'b0) begin
            failures++;
            $display("FAIL first_ready_decode: got %b required 0", evt_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (evt_ready !== 1'b0 || voice_active !== 8'h00) begin
            failures++;
            $display("FAIL first_commit_state: ready=%b active=%h required 0 00", evt_ready, voice_active);
        end
        @(posedge clk);
        #1;
        checks++;
        if (vb(0) !== 16'h3C64 || voice_active !== 8'h01 || evt_ready !== 1'b1) begin
            failures++;
            $display("FAIL first_note: v0=%h active=%h ready=%b required 3c64 01 1", vb(0), voice_active, evt_ready);
        end
    endtask

    task automatic test_steal();
        int base;
        do_reset();
        base = steal_cnt;
        for (int i = 0; i < 8; i++) send({16'h9030 + 16'(i), 8'h40});
        checks++;
        if (voice_active !== 8'hFF || steal_cnt != base) begin
            failures++;
            $display("FAIL steal_fill: active=%h steals=%0d required ff 0", voice_active, steal_cnt - base);
        end
        checks++;
        if (vb(0) !== 16'h3040 || vb(7) !== 16'h3740) begin
            failures++;
            $display("FAIL steal_fill_notes: v0=%h v7=%h required 3040 3740", vb(0), vb(7));
        end
        send(24'h903840);
        checks++;
        if (vb(0) !== 16'h3840 || steal_pulse !== 1'b1 || vb(1) !== 16'h3140) begin
            failures++;
            $display("FAIL steal_oldest: v0=%h pulse=%b v1=%h required 3840 1 3140", vb(0), steal_pulse, vb(1));
        end
        @(posedge clk);
        #1;
        checks++;
        if (steal_pulse !== 1'b0 || steal_cnt != base + 1) begin
            failures++;
            $display("FAIL steal_once: pulse=%b count=%0d required 0 1", steal_pulse, steal_cnt - base);
        end
        send(24'h903940);
        checks++;
        if (vb(1) !== 16'h3940 || vb(0) !== 16'h3840) begin
            failures++;
            $display("FAIL steal_next_oldest: v1=%h v0=%h required 3940 3840", vb(1), vb(0));
        end
    endtask

    task automatic test_note_off();
        do_reset();
        send(24'h903040);
        send(24'h903140);
        send(24'h903240);
        send(24'h803100);
        checks++;
        if (vb(1) !== 16'h0000 || voice_active !== 8'h05 || vb(2) !== 16'h3240) begin
            failures++;
            $display("FAIL note_off: v1=%h active=%h v2=%h required 0000 05 3240", vb(1), voice_active, vb(2));
        end
        send(24'h903300);
        checks++;
        if (voice_active !== 8'h05 || vb(0) !== 16'h3040 || vb(2) !== 16'h3240) begin
            failures++;
            $display("FAIL note_off_nomatch: active=%h v0=%h v2=%h required 05 3040 3240", voice_active, vb(0), vb(2));
        end
        send(24'h904050);
        checks++;
        if (vb(1) !== 16'h4050 || voice_active !== 8'h07) begin
            failures++;
            $display("FAIL reuse_free: v1=%h active=%h required 4050 07", vb(1), voice_active);
        end
    endtask

    task automatic test_all_off();
        int base;
        do_reset();
        base = steal_cnt;
        send(24'h903C40);
        send(24'h903E40);
        send(24'h914040);
        send(24'hB07B00);
        checks++;
        if (voice_active !== 8'h04 || vb(0) !== 16'h0000 || vb(2) !== 16'h4040) begin
            failures++;
            $display("FAIL all_off: active=%h v0=%h v2=%h required 04 0000 4040", voice_active, vb(0), vb(2));
        end
        send(24'h903C20);
        send(24'h903C20);
        checks++;
        if (voice_active !== 8'h05 || vb(0) !== 16'h3C20 || vb(1) !== 16'h0000 || steal_cnt != base) begin
            failures++;
            $display("FAIL retrigger: active=%h v0=%h v1=%h steals=%0d required 05 3c20 0000 0",
                     voice_active, vb(0), vb(1), steal_cnt - base);
        end
        send(24'hB17800);
        checks++;
        if (voice_active !== 8'h01) begin
            failures++;
            $display("FAIL all_off_78: active=%h required 01", voice_active);
        end
    endtask

    task automatic test_ch_mask();
        do_reset();
        @(negedge clk);
        evt_valid = 1'b1;
        evt_data  = 24'h913C64;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (m_ready !== 1'b0) begin
            failures++;
            $display("FAIL mask_busy: ready=%b required 0", m_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_ready !== 1'b1 || m_active !== 8'h00 || m_bus !== '0) begin
            failures++;
            $display("FAIL mask_ignore: ready=%b active=%h required 1 00", m_ready, m_active);
        end
        send(24'hC05000);
        checks++;
        if (m_active !== 8'h00 || m_bus !== '0) begin
            failures++;
            $display("FAIL ignore_prog_change: active=%h required 00", m_active);
        end
        send(24'h903C64);
        checks++;
        if (m_bus[15:0] !== 16'h3C64 || m_active !== 8'h01) begin
            failures++;
            $display("FAIL mask_accept_ch0: v0=%h active=%h required 3c64 01", m_bus[15:0], m_active);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(24'h903040);
        @(negedge clk);
        evt_valid = 1'b1;
        evt_data  = 24'h903C64;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (voice_bus !== '0 || voice_active !== 8'h00 || steal_pulse !== 1'b0 || evt_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: bus=%h active=%h ready=%b required 0 00 1", voice_bus, voice_active, evt_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (voice_active !== 8'h00) begin
            failures++;
            $display("FAIL reset_release: active=%h required 00", voice_active);
        end
        send(24'h904564);
        checks++;
        if (vb(0) !== 16'h4564 || voice_active !== 8'h01) begin
            failures++;
            $display("FAIL after_reset_note: v0=%h active=%h required 4564 01", vb(0), voice_active);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        evt_valid = 1'b1;
        evt_data  = 24'h903C64;
        @(posedge clk);
        #1 evt_data = 24'h904050;
        @(posedge clk);
        #1;
        checks++;
        if (evt_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy: ready=%b required 0", evt_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (vb(0) !== 16'h3C64 || voice_active !== 8'h01 || evt_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: v0=%h active=%h ready=%b required 3c64 01 1", vb(0), voice_active, evt_ready);
        end
        @(posedge clk);
        #1 evt_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (vb(1) !== 16'h4050 || voice_active !== 8'h03 || vb(0) !== 16'h3C64) begin
            failures++;
            $display("FAIL b2b_second: v1=%h active=%h v0=%h required 4050 03 3c64", vb(1), voice_active, vb(0));
        end
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_steal();
        test_note_off();
        test_all_off();
        test_ch_mask();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
